tp_mem_copy_engine: RTL and testbench



---
 rtl/tp_mem_pkg.sv | 18 +
 rtl/tp_mem_copy_engine.sv | 156 +++++++++++++++
 tb/tb_tp_mem_copy_engine.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tp_mem_pkg.sv
// tp_mem_pkg: shared state, mode and default width definitions
// for the two-port memory copy/fill engine.
package tp_mem_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 32;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_t;

endpackage

// File: rtl/tp_mem_copy_engine.sv
// tp_mem_copy_engine: block copy/fill initiator driving a read-only
// port A and a write-only port B of a registered two-port memory.
module tp_mem_copy_engine
   import tp_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              aborted,
   output logic              wen_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_in_a,
   input  logic [DATA_W-1:0] data_out_a,
   output logic              wen_b,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_in_b
);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [ADDR_W-1:0] ra_q, ra_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic              err_q, err_d;
   logic              abt_q, abt_d;

   logic [ADDR_W-1:0] gap;
   logic              hazard;
   logic              accept;
   logic              last;

   // A forward-overlapping copy would read words it already overwrote.
   assign gap    = dst_addr - src_addr;
   assign hazard = (mode == MODE_COPY) && (gap != '0) &&
                   (LEN_W'(gap) < len);
   assign accept = start && !abort;
   assign last   = (cnt_q == LEN_W'(1));

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      fill_d  = fill_q;
      ra_d    = ra_q;
      wa_d    = wa_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      err_d   = 1'b0;
      abt_d   = 1'b0;
      unique case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            wen_d   = 1'b0;
            if (accept) begin
               mode_d = mode;
               fill_d = fill_value;
               cnt_d  = len;
               if (len == '0) begin
                  state_d = FIN;
               end else if (hazard) begin
                  err_d = 1'b1;
               end else begin
                  state_d = RUN;
                  ra_d    = src_addr;
                  wa_d    = dst_addr;
                  wen_d   = (mode == MODE_FILL);
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               wen_d   = 1'b0;
               abt_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
               // Write pointer advances only after a write was issued.
               wa_d  = wen_q ? wa_q + ADDR_W'(1) : wa_q;
               if (mode_q == MODE_FILL) begin
                  wen_d = !last;
                  if (last) state_d = FIN;
               end else begin
                  wen_d = 1'b1;
                  if (last) state_d = DRAIN;
                  else      ra_d    = ra_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            wen_d = 1'b0;
            if (abort) begin
               state_d = IDLE;
               abt_d   = 1'b1;
            end else begin
               state_d = FIN;
            end
         end
         default: begin
            state_d = IDLE;
            wen_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_COPY;
         fill_q  <= '0;
         ra_q    <= '0;
         wa_q    <= '0;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
         abt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         fill_q  <= fill_d;
         ra_q    <= ra_d;
         wa_q    <= wa_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         err_q   <= err_d;
         abt_q   <= abt_d;
      end
   end

   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == FIN);
   assign err       = err_q;
   assign aborted   = abt_q;
   assign wen_a     = 1'b0;
   assign data_in_a = '0;
   assign addr_a    = ra_q;
   assign wen_b     = wen_q;
   assign addr_b    = wa_q;
   // Copy data flows straight from the registered read port.
   assign data_in_b = !wen_q ? '0 :
                      (mode_q == MODE_FILL) ? fill_q : data_out_a;

endmodule

// File: tb/tb_tp_mem_copy_engine.sv
// tb_tp_mem_copy_engine: engine plus a registered two-port memory,
// checked against a word-level reference memory.
module tb_tp_mem_copy_engine;

   localparam int N    = 16384;
   localparam int MASK = N - 1;

   logic        clk, rst, start, mode, abort;
   logic [13:0] src_addr, dst_addr;
   logic [14:0] len;
   logic [31:0] fill_value;
   logic        busy, done, err, aborted, wen_a, wen_b;
   logic [13:0] addr_a, addr_b;
   logic [31:0] data_in_a, data_in_b, data_out_a;

   logic [31:0] mem     [0:N-1];
   logic [31:0] ref_mem [0:N-1];
   logic        seed_en, pre_en;
   logic [13:0] pre_a;
   logic [31:0] pre_d;

   int errors = 0;
   int checks = 0;

   tp_mem_copy_engine #(.ADDR_W(14), .DATA_W(32), .LEN_W(15)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .fill_value(fill_value), .abort(abort),
      .busy(busy), .done(done), .err(err), .aborted(aborted),
      .wen_a(wen_a), .addr_a(addr_a), .data_in_a(data_in_a),
      .data_out_a(data_out_a),
      .wen_b(wen_b), .addr_b(addr_b), .data_in_b(data_in_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h0BAD0000;
   endfunction

   // Two-port memory, registered read with one-cycle latency.
   always @(posedge clk) begin
      if (seed_en) begin
         for (int i = 0; i < N; i++) mem[i] <= pat(i);
      end else begin
         if (pre_en) mem[pre_a] <= pre_d;
         if (wen_b)  mem[addr_b] <= data_in_b;
      end
      data_out_a <= mem[addr_a];
   end

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic poke(input int a, input logic [31:0] v);
      @(negedge clk);
      pre_en = 1'b1;
      pre_a  = 14'(a);
      pre_d  = v;
      @(negedge clk);
      pre_en = 1'b0;
      ref_mem[a & MASK] = v;
   endtask

   // Reference: outcome timing and memory effect of one request.
   task automatic ref_xfer(input logic m, input int s, input int d,
                           input int l, input logic [31:0] f,
                           input int ab, output int e_done,
                           output int e_err, output int e_ab,
                           output int e_busy, output int e_wr);
      int rel, lat, n;
      logic [31:0] q[$];
      e_done = -1; e_err = -1; e_ab = -1; e_busy = 0; e_wr = 0;
      rel = (d - s) & MASK;
      if (l == 0) begin
         e_done = 1;
      end else if (!m && rel >= 1 && rel <= l - 1) begin
         e_err = 1;
      end else begin
         lat = m ? l + 1 : l + 2;
         if (ab >= 1 && ab <= lat - 1) begin
            n = m ? ab : ab - 1;
            e_ab = ab + 1;
            e_busy = ab;
         end else begin
            n = l;
            e_done = lat;
            e_busy = lat - 1;
         end
         e_wr = n;
         for (int k = 0; k < n; k++)
            q.push_back(m ? f : ref_mem[(s + k) & MASK]);
         for (int k = 0; k < n; k++)
            ref_mem[(d + k) & MASK] = q[k];
      end
   endtask

   task automatic do_xfer(input logic m, input int s, input int d,
                          input int l, input logic [31:0] f,
                          input int ab, input int noise,
                          output int o_done, output int o_err,
                          output int o_ab, output int o_busy,
                          output int o_wr, output int o_pulses);
      o_done = -1; o_err = -1; o_ab = -1;
      o_busy = 0; o_wr = 0; o_pulses = 0;
      @(negedge clk);
      mode = m; src_addr = 14'(s); dst_addr = 14'(d);
      len = 15'(l); fill_value = f; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= l + 6; c++) begin
         @(negedge clk);
         if (done && o_done < 0) o_done = c;
         if (err && o_err < 0) o_err = c;
         if (aborted && o_ab < 0) o_ab = c;
         if (busy) o_busy++;
         if (wen_b) o_wr++;
         if (done || err || aborted) o_pulses++;
         abort = (c == ab);
         start = (c == noise);
         if (c == noise) begin
            mode = ~m; src_addr = 14'($urandom);
            dst_addr = 14'($urandom); len = 15'($urandom_range(1, 9));
            fill_value = $urandom;
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, err, aborted, wen_a, wen_b} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000000",
                  {busy, done, err, aborted, wen_a, wen_b});
      end
      checks++;
      if (addr_a !== 14'h0 || addr_b !== 14'h0) begin
         errors++;
         $display("FAIL reset_addr: got a=%h b=%h want 0 0", addr_a, addr_b);
      end
      checks++;
      if (data_in_a !== 32'h0 || data_in_b !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got a=%h b=%h want 0 0",
                  data_in_a, data_in_b);
      end
   endtask

   task automatic test_copy();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      for (int i = 0; i < 4; i++) poke(16'h10 + i, 32'hA0A0_0000 + 32'(i));
      ref_xfer(0, 16'h10, 16'h100, 4, 0, 0, ed, ee, ea, eb, ew);
      do_xfer(0, 16'h10, 16'h100, 4, 0, 0, 0, od, oe, oa, ob, ow, op);
      checks++;
      if (od !== 6) begin
         errors++; $display("FAIL copy_done_lat: got %0d want 6", od);
      end
      checks++;
      if (ob !== 5) begin
         errors++; $display("FAIL copy_busy: got %0d want 5", ob);
      end
      checks++;
      if (ow !== 4 || op !== 1) begin
         errors++;
         $display("FAIL copy_wr_pulses: got %0d/%0d want 4/1", ow, op);
      end
      nd = mem_diffs();
      checks++;
      if (nd !== 0) begin
         errors++; $display("FAIL copy_mem: got %0d diffs want 0", nd);
      end
   endtask

   task automatic test_fill_wrap();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      ref_xfer(1, 16'h3FFE, 16'h3FFE, 4, 32'hDEADBEEF, 0,
               ed, ee, ea, eb, ew);
      do_xfer(1, 16'h3FFE, 16'h3FFE, 4, 32'hDEADBEEF, 0, 0,
              od, oe, oa, ob, ow, op);
      checks++;
      if (od !== 5 || ob !== 4) begin
         errors++;
         $display("FAIL fill_lat: got done=%0d busy=%0d want 5 4", od, ob);
      end
      checks++;
      if (mem[1] !== 32'hDEADBEEF || mem[2] !== pat(2)) begin
         errors++;
         $display("FAIL fill_wrap: got %h %h want deadbeef %h",
                  mem[1], mem[2], pat(2));
      end
      nd = mem_diffs();
      checks++;
      if (nd !== 0) begin
         errors++; $display("FAIL fill_mem: got %0d diffs want 0", nd);
      end
   endtask

   task automatic test_hazard();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      do_xfer(0, 16'h20, 16'h22, 4, 0, 0, 0, od, oe, oa, ob, ow, op);
      checks++;
      if (oe !== 1 || od !== -1 || op !== 1) begin
         errors++;
         $display("FAIL hazard_err: got err=%0d done=%0d n=%0d want 1 -1 1",
                  oe, od, op);
      end
      checks++;
      if (ow !== 0 || ob !== 0) begin
         errors++;
         $display("FAIL hazard_quiet: got wr=%0d busy=%0d want 0 0", ow, ob);
      end
      ref_xfer(0, 16'h20, 16'h1E, 4, 0, 0, ed, ee, ea, eb, ew);
      do_xfer(0, 16'h20, 16'h1E, 4, 0, 0, 0, od, oe, oa, ob, ow, op);
      nd = mem_diffs();
      checks++;
      if (od !== 6 || oe !== -1 || nd !== 0) begin
         errors++;
         $display("FAIL back_overlap: got done=%0d err=%0d diffs=%0d want 6 -1 0",
                  od, oe, nd);
      end
   endtask

   task automatic test_len_zero();
      int od, oe, oa, ob, ow, op;
      do_xfer(0, 16'h40, 16'h41, 0, 0, 0, 0, od, oe, oa, ob, ow, op);
      checks++;
      if (od !== 1 || ow !== 0 || ob !== 0 || op !== 1) begin
         errors++;
         $display("FAIL len_zero: got done=%0d wr=%0d busy=%0d want 1 0 0",
                  od, ow, ob);
      end
   endtask

   task automatic test_abort();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      ref_xfer(0, 16'h800, 16'h900, 8, 0, 3, ed, ee, ea, eb, ew);
      do_xfer(0, 16'h800, 16'h900, 8, 0, 3, 0, od, oe, oa, ob, ow, op);
      checks++;
      if (oa !== 4 || od !== -1 || op !== 1) begin
         errors++;
         $display("FAIL abort_pulse: got ab=%0d done=%0d want 4 -1", oa, od);
      end
      nd = mem_diffs();
      checks++;
      if (ow !== 2 || nd !== 0) begin
         errors++;
         $display("FAIL abort_writes: got wr=%0d diffs=%0d want 2 0", ow, nd);
      end
   endtask

   task automatic test_abort_start_idle();
      int nb = 0, nw = 0, np = 0;
      @(negedge clk);
      mode = 1'b1; dst_addr = 14'h500; len = 15'd4;
      fill_value = 32'h1234_5678; start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; abort = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (busy) nb++;
         if (wen_b) nw++;
         if (done || err || aborted) np++;
      end
      checks++;
      if (nb !== 0 || nw !== 0 || np !== 0) begin
         errors++;
         $display("FAIL abort_wins: got busy=%0d wr=%0d pulses=%0d want 0",
                  nb, nw, np);
      end
   endtask

   task automatic test_start_ignored();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      ref_xfer(1, 0, 16'h600, 6, 32'hC0FFEE00, 0, ed, ee, ea, eb, ew);
      do_xfer(1, 0, 16'h600, 6, 32'hC0FFEE00, 0, 2,
              od, oe, oa, ob, ow, op);
      nd = mem_diffs();
      checks++;
      if (od !== 7 || ow !== 6 || nd !== 0) begin
         errors++;
         $display("FAIL start_busy: got done=%0d wr=%0d diffs=%0d want 7 6 0",
                  od, ow, nd);
      end
   endtask

   task automatic test_back_to_back();
      int ed, ee, ea, eb, ew, first = -1, second = -1, nd;
      ref_xfer(1, 0, 16'h300, 3, 32'hF1F1F1F1, 0, ed, ee, ea, eb, ew);
      ref_xfer(0, 16'h10, 16'h310, 2, 0, 0, ed, ee, ea, eb, ew);
      @(negedge clk);
      mode = 1'b1; dst_addr = 14'h300; len = 15'd3;
      fill_value = 32'hF1F1F1F1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            if (first < 0) begin
               first = c;
               mode = 1'b0; src_addr = 14'h10; dst_addr = 14'h310;
               len = 15'd2; start = 1'b1;
            end else if (second < 0) begin
               second = c;
            end
         end
      end
      start = 1'b0;
      nd = mem_diffs();
      checks++;
      if (first !== 4 || second !== 8 || nd !== 0) begin
         errors++;
         $display("FAIL back_to_back: got %0d %0d diffs=%0d want 4 8 0",
                  first, second, nd);
      end
   endtask

   task automatic test_reset_mid();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      logic sane;
      @(negedge clk);
      mode = 1'b1; dst_addr = 14'h200; len = 15'd10;
      fill_value = 32'h5EED5EED; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      sane = wen_b;
      rst = 1'b1;
      #1;
      checks++;
      if (sane !== 1'b1 || wen_b !== 1'b0) begin
         errors++;
         $display("FAIL rst_async_wen: got before=%b after=%b want 1 0",
                  sane, wen_b);
      end
      checks++;
      if ({busy, done, err, aborted} !== 4'b0 || addr_b !== 14'h0 ||
          addr_a !== 14'h0 || data_in_b !== 32'h0) begin
         errors++;
         $display("FAIL rst_outputs: got flags=%b ab=%h aa=%h db=%h want 0",
                  {busy, done, err, aborted}, addr_b, addr_a, data_in_b);
      end
      for (int k = 0; k < 3; k++) ref_mem[16'h200 + k] = 32'h5EED5EED;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ref_xfer(1, 0, 16'h400, 5, 32'h0F0F0F0F, 0, ed, ee, ea, eb, ew);
      do_xfer(1, 0, 16'h400, 5, 32'h0F0F0F0F, 0, 0,
              od, oe, oa, ob, ow, op);
      nd = mem_diffs();
      checks++;
      if (od !== 6 || nd !== 0) begin
         errors++;
         $display("FAIL rst_recover: got done=%0d diffs=%0d want 6 0", od, nd);
      end
   endtask

   task automatic test_full_len();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      ref_xfer(0, 16'h1234, 16'h1234, N, 0, 0, ed, ee, ea, eb, ew);
      do_xfer(0, 16'h1234, 16'h1234, N, 0, 0, 0, od, oe, oa, ob, ow, op);
      nd = mem_diffs();
      checks++;
      if (od !== N + 2 || ow !== N || nd !== 0) begin
         errors++;
         $display("FAIL full_len: got done=%0d wr=%0d diffs=%0d want %0d %0d 0",
                  od, ow, nd, N + 2, N);
      end
   endtask

   task automatic test_random();
      int ed, ee, ea, eb, ew, od, oe, oa, ob, ow, op, nd;
      int s, d, l, ab;
      logic m;
      logic [31:0] f;
      for (int it = 0; it < 25; it++) begin
         m = 1'($urandom_range(0, 1));
         s = int'($urandom_range(0, N - 1));
         l = int'($urandom_range(0, 20));
         if ($urandom_range(0, 2) == 0)
            d = (s + int'($urandom_range(0, l + 1))) & MASK;
         else
            d = int'($urandom_range(0, N - 1));
         ab = 0;
         if (l > 0 && $urandom_range(0, 3) == 0)
            ab = int'($urandom_range(1, m ? l : l + 1));
         f = $urandom;
         ref_xfer(m, s, d, l, f, ab, ed, ee, ea, eb, ew);
         do_xfer(m, s, d, l, f, ab, 0, od, oe, oa, ob, ow, op);
         checks++;
         if (od !== ed || oe !== ee || oa !== ea) begin
            errors++;
            $display("FAIL rnd%0d_pulse: got %0d/%0d/%0d want %0d/%0d/%0d",
                     it, od, oe, oa, ed, ee, ea);
         end
         checks++;
         if (ob !== eb || ow !== ew) begin
            errors++;
            $display("FAIL rnd%0d_busy_wr: got %0d/%0d want %0d/%0d",
                     it, ob, ow, eb, ew);
         end
         nd = mem_diffs();
         checks++;
         if (nd !== 0) begin
            errors++;
            $display("FAIL rnd%0d_mem: got %0d diffs want 0", it, nd);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0; fill_value = '0;
      pre_en = 1'b0; pre_a = '0; pre_d = '0; seed_en = 1'b1;
      for (int i = 0; i < N; i++) ref_mem[i] = pat(i);
      @(posedge clk);
      @(negedge clk);
      seed_en = 1'b0;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_copy();
      test_fill_wrap();
      test_hazard();
      test_len_zero();
      test_abort();
      test_abort_start_idle();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_full_len();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
